// File: rtl/fcfs_hold_arbiter_if.sv
// fcfs_hold_arbiter_if: request/grant bundle between requesters and the arbiter
interface fcfs_hold_arbiter_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout;
    logic [2:0] q_count;
    modport master (output req, input grant, grant_id, busy, timeout, q_count);
    modport slave  (input req, output grant, grant_id, busy, timeout, q_count);
endinterface

// File: rtl/fcfs_hold_arbiter.sv
// fcfs_hold_arbiter: four-way first-come-first-served arbiter with bounded hold and timeout re-queue
module fcfs_hold_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int HW       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    fcfs_hold_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
    state_t        state_q, state_d;
    logic [3:0]    grant_q, grant_d;
    logic [1:0]    id_q, id_d;
    logic          busy_q, busy_d;
    logic          timeout_q, timeout_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [3:0]    pend_q, pend_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [1:0]    q_q [4];
    logic [1:0]    q_d [4];
    logic          pop, tpush;
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        id_d      = id_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        pend_d    = pend_q;
        pop       = 1'b0;
        tpush     = 1'b0;
        case (state_q)
            IDLE: if (cnt_q != 3'd0) begin
                pop = 1'b1;
                if (bus.req[q_q[0]]) begin
                    grant_d = 4'b0001 << q_q[0];
                    id_d    = q_q[0];
                    hold_d  = HW'(1);
                    state_d = GRANT;
                end else pend_d[q_q[0]] = 1'b0;
            end
            GRANT: if (!bus.req[id_q]) begin
                grant_d      = 4'b0000;
                id_d         = 2'd0;
                hold_d       = '0;
                pend_d[id_q] = 1'b0;
                state_d      = GAP;
            end else if (hold_q == HW'(MAX_HOLD)) begin
                grant_d   = 4'b0000;
                id_d      = 2'd0;
                hold_d    = '0;
                timeout_d = 1'b1;
                tpush     = 1'b1;
                state_d   = GAP;
            end else hold_d = hold_q + 1'b1;
            default: state_d = IDLE;
        endcase
        busy_d = |grant_d;
        q_d    = q_q;
        cnt_d  = cnt_q;
        if (pop) begin
            q_d[0] = q_q[1];
            q_d[1] = q_q[2];
            q_d[2] = q_q[3];
            q_d[3] = 2'd0;
            cnt_d  = cnt_q - 3'd1;
        end
        // the timed-out owner goes ahead of any same-edge newcomers
        if (tpush) begin
            q_d[cnt_d[1:0]] = id_q;
            cnt_d           = cnt_d + 3'd1;
        end
        for (int i = 0; i < 4; i++) begin
            if (bus.req[i] && !pend_q[i]) begin
                q_d[cnt_d[1:0]] = 2'(i);
                cnt_d           = cnt_d + 3'd1;
                pend_d[i]       = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            id_q      <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
            pend_q    <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < 4; i++) q_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            q_q       <= q_d;
        end
    end
    assign bus.grant    = grant_q;
    assign bus.grant_id = id_q;
    assign bus.busy     = busy_q;
    assign bus.timeout  = timeout_q;
    assign bus.q_count  = cnt_q;
endmodule

// File: tb/tb_fcfs_hold_arbiter.sv
// tb_fcfs_hold_arbiter: directed checks of ordering, hold, timeout, stale drop and async reset
module tb_fcfs_hold_arbiter;
    logic clk;
    logic rst_n;
    int   err;
    int   chk;
    fcfs_hold_arbiter_if ba ();
    fcfs_hold_arbiter_if bb ();
    fcfs_hold_arbiter #(.MAX_HOLD(8), .HW(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ba.slave));
    fcfs_hold_arbiter #(.MAX_HOLD(4), .HW(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bb.slave));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    // packed view: {grant, grant_id, busy, timeout, q_count}
    function automatic logic [10:0] ex(input logic [3:0] g, input logic [1:0] id, input logic t, input logic [2:0] q);
        return {g, id, g != 4'b0000, t, q};
    endfunction
    function automatic logic [10:0] sa();
        return {ba.grant, ba.grant_id, ba.busy, ba.timeout, ba.q_count};
    endfunction
    function automatic logic [10:0] sb();
        return {bb.grant, bb.grant_id, bb.busy, bb.timeout, bb.q_count};
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        ba.req = 4'b0000;
        bb.req = 4'b0000;
        #3;
        chk++; if (sa() !== ex(4'b0000, 2'd0, 1'b0, 3'd0)) begin err++; $display("FAIL reset_a got %b want %b", sa(), ex(4'b0000, 2'd0, 1'b0, 3'd0)); end
        chk++; if (sb() !== ex(4'b0000, 2'd0, 1'b0, 3'd0)) begin err++; $display("FAIL reset_b got %b want %b", sb(), ex(4'b0000, 2'd0, 1'b0, 3'd0)); end
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    task automatic test_hold_timeout();
        ba.req = 4'b0001;
        tick();
        chk++; if (sa() !== ex(4'b0000, 2'd0, 1'b0, 3'd1)) begin err++; $display("FAIL t1_queued got %b want %b", sa(), ex(4'b0000, 2'd0, 1'b0, 3'd1)); end
        tick();
        chk++; if (sa() !== ex(4'b0001, 2'd0, 1'b0, 3'd0)) begin err++; $display("FAIL t1_grant got %b want %b", sa(), ex(4'b0001, 2'd0, 1'b0, 3'd0)); end
        for (int i = 2; i <= 8; i++) begin
            tick();
            chk++; if (sa() !== ex(4'b0001, 2'd0, 1'b0, 3'd0)) begin err++; $display("FAIL t1_hold%0d got %b want %b", i, sa(), ex(4'b0001, 2'd0, 1'b0, 3'd0)); end
        end
        tick();
        chk++; if (sa() !== ex(4'b0000, 2'd0, 1'b1, 3'd1)) begin err++; $display("FAIL t1_timeout got %b want %b", sa(), ex(4'b0000, 2'd0, 1'b1, 3'd1)); end
        tick();
        chk++; if (sa() !== ex(4'b0000, 2'd0, 1'b0, 3'd1)) begin err++; $display("FAIL t1_gap got %b want %b", sa(), ex(4'b0000, 2'd0, 1'b0, 3'd1)); end
        tick();
        chk++; if (sa() !== ex(4'b0001, 2'd0, 1'b0, 3'd0)) begin err++; $display("FAIL t1_regrant got %b want %b", sa(), ex(4'b0001, 2'd0, 1'b0, 3'd0)); end
        ba.req = 4'b0000;
        tick();
        tick();
        chk++; if (sa() !== ex(4'b0000, 2'd0, 1'b0, 3'd0)) begin err++; $display("FAIL t1_idle got %b want %b", sa(), ex(4'b0000, 2'd0, 1'b0, 3'd0)); end
    endtask
    task automatic test_ordering();
        ba.req = 4'b0100;
        tick();
        chk++; if (sa() !== ex(4'b0000, 2'd0, 1'b0, 3'd1)) begin err++; $display("FAIL t2_q1 got %b want %b", sa(), ex(4'b0000, 2'd0, 1'b0, 3'd1)); end
        ba.req = 4'b1101;
        tick();
        chk++; if (sa() !== ex(4'b0100, 2'd2, 1'b0, 3'd2)) begin err++; $display("FAIL t2_g2 got %b want %b", sa(), ex(4'b0100, 2'd2, 1'b0, 3'd2)); end
        ba.req = 4'b1001;
        tick();
        chk++; if (sa() !== ex(4'b0000, 2'd0, 1'b0, 3'd2)) begin err++; $display("FAIL t2_rel2 got %b want %b", sa(), ex(4'b0000, 2'd0, 1'b0, 3'd2)); end
        tick();
        tick();
        chk++; if (sa() !== ex(4'b0001, 2'd0, 1'b0, 3'd1)) begin err++; $display("FAIL t2_g0 got %b want %b", sa(), ex(4'b0001, 2'd0, 1'b0, 3'd1)); end
        ba.req = 4'b1000;
        tick();
        tick();
        tick();
        chk++; if (sa() !== ex(4'b1000, 2'd3, 1'b0, 3'd0)) begin err++; $display("FAIL t2_g3 got %b want %b", sa(), ex(4'b1000, 2'd3, 1'b0, 3'd0)); end
        ba.req = 4'b0000;
        tick();
        tick();
    endtask
    task automatic test_release();
        ba.req = 4'b0010;
        tick();
        ba.req = 4'b1010;
        tick();
        chk++; if (sa() !== ex(4'b0010, 2'd1, 1'b0, 3'd1)) begin err++; $display("FAIL t3_g1 got %b want %b", sa(), ex(4'b0010, 2'd1, 1'b0, 3'd1)); end
        tick();
        tick();
        chk++; if (sa() !== ex(4'b0010, 2'd1, 1'b0, 3'd1)) begin err++; $display("FAIL t3_held got %b want %b", sa(), ex(4'b0010, 2'd1, 1'b0, 3'd1)); end
        ba.req = 4'b1000;
        tick();
        chk++; if (sa() !== ex(4'b0000, 2'd0, 1'b0, 3'd1)) begin err++; $display("FAIL t3_drop got %b want %b", sa(), ex(4'b0000, 2'd0, 1'b0, 3'd1)); end
        tick();
        chk++; if (sa() !== ex(4'b0000, 2'd0, 1'b0, 3'd1)) begin err++; $display("FAIL t3_gap got %b want %b", sa(), ex(4'b0000, 2'd0, 1'b0, 3'd1)); end
        tick();
        chk++; if (sa() !== ex(4'b1000, 2'd3, 1'b0, 3'd0)) begin err++; $display("FAIL t3_g3 got %b want %b", sa(), ex(4'b1000, 2'd3, 1'b0, 3'd0)); end
        ba.req = 4'b0000;
        tick();
        tick();
    endtask
    task automatic test_stale();
        ba.req = 4'b0100;
        tick();
        ba.req = 4'b0111;
        tick();
        chk++; if (sa() !== ex(4'b0100, 2'd2, 1'b0, 3'd2)) begin err++; $display("FAIL t4_g2 got %b want %b", sa(), ex(4'b0100, 2'd2, 1'b0, 3'd2)); end
        ba.req = 4'b0110;
        tick();
        ba.req = 4'b0010;
        tick();
        tick();
        chk++; if (sa() !== ex(4'b0000, 2'd0, 1'b0, 3'd2)) begin err++; $display("FAIL t4_idle got %b want %b", sa(), ex(4'b0000, 2'd0, 1'b0, 3'd2)); end
        tick();
        chk++; if (sa() !== ex(4'b0000, 2'd0, 1'b0, 3'd1)) begin err++; $display("FAIL t4_stale got %b want %b", sa(), ex(4'b0000, 2'd0, 1'b0, 3'd1)); end
        tick();
        chk++; if (sa() !== ex(4'b0010, 2'd1, 1'b0, 3'd0)) begin err++; $display("FAIL t4_g1 got %b want %b", sa(), ex(4'b0010, 2'd1, 1'b0, 3'd0)); end
        ba.req = 4'b0000;
        tick();
        tick();
    endtask
    task automatic test_timeout_waiters();
        logic [3:0] g;
        logic [1:0] id;
        bb.req = 4'b1111;
        tick();
        chk++; if (sb() !== ex(4'b0000, 2'd0, 1'b0, 3'd4)) begin err++; $display("FAIL t5_q4 got %b want %b", sb(), ex(4'b0000, 2'd0, 1'b0, 3'd4)); end
        for (int k = 0; k < 5; k++) begin
            id = 2'(k % 4);
            g  = 4'b0001 << id;
            for (int c = 0; c < 4; c++) begin
                tick();
                chk++; if (sb() !== ex(g, id, 1'b0, 3'd3)) begin err++; $display("FAIL t5_grant%0d_%0d got %b want %b", k, c, sb(), ex(g, id, 1'b0, 3'd3)); end
            end
            tick();
            chk++; if (sb() !== ex(4'b0000, 2'd0, 1'b1, 3'd4)) begin err++; $display("FAIL t5_to%0d got %b want %b", k, sb(), ex(4'b0000, 2'd0, 1'b1, 3'd4)); end
            tick();
            chk++; if (sb() !== ex(4'b0000, 2'd0, 1'b0, 3'd4)) begin err++; $display("FAIL t5_gap%0d got %b want %b", k, sb(), ex(4'b0000, 2'd0, 1'b0, 3'd4)); end
        end
        bb.req = 4'b0000;
    endtask
    task automatic test_async_reset();
        ba.req = 4'b0100;
        tick();
        ba.req = 4'b0111;
        tick();
        chk++; if (sa() !== ex(4'b0100, 2'd2, 1'b0, 3'd2)) begin err++; $display("FAIL t6_pre got %b want %b", sa(), ex(4'b0100, 2'd2, 1'b0, 3'd2)); end
        #2;
        rst_n = 1'b0;
        #1;
        chk++; if (sa() !== ex(4'b0000, 2'd0, 1'b0, 3'd0)) begin err++; $display("FAIL t6_async got %b want %b", sa(), ex(4'b0000, 2'd0, 1'b0, 3'd0)); end
        tick();
        chk++; if (sa() !== ex(4'b0000, 2'd0, 1'b0, 3'd0)) begin err++; $display("FAIL t6_held got %b want %b", sa(), ex(4'b0000, 2'd0, 1'b0, 3'd0)); end
        #2;
        rst_n = 1'b1;
        tick();
        chk++; if (sa() !== ex(4'b0000, 2'd0, 1'b0, 3'd3)) begin err++; $display("FAIL t6_requeue got %b want %b", sa(), ex(4'b0000, 2'd0, 1'b0, 3'd3)); end
        tick();
        chk++; if (sa() !== ex(4'b0001, 2'd0, 1'b0, 3'd2)) begin err++; $display("FAIL t6_g0 got %b want %b", sa(), ex(4'b0001, 2'd0, 1'b0, 3'd2)); end
        ba.req = 4'b0110;
        tick();
        tick();
        tick();
        chk++; if (sa() !== ex(4'b0010, 2'd1, 1'b0, 3'd1)) begin err++; $display("FAIL t6_g1 got %b want %b", sa(), ex(4'b0010, 2'd1, 1'b0, 3'd1)); end
        ba.req = 4'b0000;
    endtask
    initial begin
        err = 0;
        chk = 0;
        test_reset();
        test_hold_timeout();
        test_ordering();
        test_release();
        test_stale();
        test_timeout_waiters();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end
endmodule

// File: doc/fcfs_hold_arbiter.md
Name: fcfs_hold_arbiter

Overview:
- Four-requester first-come-first-served arbiter for a shared resource.
- Each grant is held until the owner releases it or a maximum hold time expires.
- Arrival order is kept in a 4-entry ID queue. A requester that times out is re-queued at the tail.
- Sits between the requesting units and the shared resource. It supplies the one-hot grant and an owner ID to the resource mux.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles a grant stays high. Legal range 2..255.
- HW, 8: hold-counter width. Must satisfy 2^HW > MAX_HOLD.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  4  request level per requester, index 0..3.
- grant  out  4  one-hot grant, all-zero when the resource is free.
- grant_id  out  2  index of the current owner. Value is 0 when grant is zero.
- busy  out  1  high exactly when grant != 0.
- timeout  out  1  one-cycle pulse marking a forced release.
- q_count  out  3  number of queued IDs, 0..4.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: while rst_n=0, all outputs are 0, the queue is empty, all pending flags are 0, the hold counter is 0, and state is IDLE. Assertion clears everything immediately, mid-grant included. The first edge after release behaves as IDLE with an empty queue.
- Registered outputs: all outputs are registered. req is sampled on the rising edge of clk.
- Pending flags, pend[i]:
  - Enqueue: at an edge where req[i]=1 and pend[i]=0, push i to the queue tail and set pend[i].
  - Lifetime: pend[i] stays set while i is queued or granted. It clears only on release or on a stale drop.
  - No duplicates: an ID is never in the queue twice. The queue therefore cannot overflow, and there is no overflow handling.
- Same-edge arrivals: new IDs are pushed in ascending index order. If a timeout re-queue happens at the same edge, the re-queued ID is pushed before the new arrivals.
- Queued requester that drops req: it keeps its queue slot. If it re-raises req before being popped, it keeps that place.
- FSM states: IDLE, GRANT, GAP.
- IDLE:
  - Queue empty: stay in IDLE.
  - Queue non-empty: pop the head ID h.
  - If req[h]=1 at that edge: grant <= onehot(h), grant_id <= h, busy <= 1, counter <= 1, go to GRANT.
  - If req[h]=0 (stale): clear pend[h], stay in IDLE. Each stale entry costs one cycle.
  - A push and a pop at the same edge are both performed. q_count reflects the net result.
- GRANT, owner o:
  - If req[o]=0 at the edge: grant <= 0, clear pend[o], go to GAP.
  - Else if counter == MAX_HOLD: grant <= 0, timeout <= 1 for one cycle, push o to the tail (pend[o] stays set), go to GAP.
  - Else: counter <= counter + 1.
  - Release takes priority over timeout at the same edge.
  - Grant is high for at most MAX_HOLD consecutive cycles.
- GAP: exactly one cycle with grant=0, then go to IDLE. Enqueueing continues during GAP.
- Latency:
  - Request sampled at edge k with the queue empty and FSM in IDLE: the entry is queued after edge k and grant rises after edge k+1.
  - Release sampled at edge r: grant falls after edge r. The next grant rises no earlier than after edge r+2.
- Starvation: with 4 requesters each holding up to MAX_HOLD cycles, any requester is granted within 4*(MAX_HOLD+2) cycles of being queued.
- Re-request: a requester that releases and raises req again is re-queued at the tail on the next edge where req=1 and pend=0.

Test Plan:
1. Reset, then req=0001 held high with MAX_HOLD=8.
   - grant=0001 and grant_id=0 two edges after req is first sampled.
   - grant drops after the 8th grant cycle, timeout pulses once.
   - After GAP, req 0 is re-granted.
2. Ordering and same-edge arrival.
   - req[2] raised first, then req[0] and req[3] raised together one cycle later.
   - Grant order is 2, 0, 3.
   - q_count sequence after the edges is 1, 2, 2, 1.
3. Owner release.
   - req[1] granted and held for 3 cycles, then dropped.
   - grant=0000 after the next edge, followed by one GAP cycle.
   - Queued req[3] is granted after edge r+2.
4. Stale entry.
   - req[0] and req[1] queued behind owner 2. req[0] drops while queued.
   - After 2 releases, entry 0 is discarded in one IDLE cycle and grant=0010 follows.
5. Timeout with waiters.
   - MAX_HOLD=4, all four req held high.
   - Grants rotate 0,1,2,3,0 with 4-cycle grants, a timeout pulse and 1-cycle GAP after each, and 1 IDLE cycle between grants.
6. Async reset mid-grant.
   - rst_n low between edges while grant=0100 and q_count=2.
   - All outputs read 0 immediately, without waiting for a clock edge.
   - After rst_n is released with req still high, requests re-enqueue in index order.
